dom_rand_feeder: RTL

- Upstream neighbour of the 5-share DOM AND gadget.
- Supplies the ten pairwise 8-bit randomness bytes (r01..r34) that the gadget needs fresh on every clock.
- Source is an 80-bit LFSR with a seed-load handshake, a warm-up phase and a valid/ready output handshake.
- One instance feeds one gadget; the gadget's r inputs connect directly to this block's outputs.

---
 rtl/dom_rand_feeder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dom_rand_feeder.sv
// Randomness feeder for the 5-share DOM AND gadget: an 80-bit LFSR with seed load, warm-up and
// valid/ready output. Define DOM_RAND_HEALTH_EN to build the repetition health test (alarm).
module dom_rand_feeder #(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter logic [79:0] ZERO_SEED_SUB = 80'h0000_0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] seed,
  input  logic        seed_valid,
  input  logic        rnd_ready,
  output logic        rnd_valid,
  output logic [7:0]  r01,
  output logic [7:0]  r02,
  output logic [7:0]  r03,
  output logic [7:0]  r04,
  output logic [7:0]  r12,
  output logic [7:0]  r13,
  output logic [7:0]  r14,
  output logic [7:0]  r23,
  output logic [7:0]  r24,
  output logic [7:0]  r34,
  output logic        alarm
);

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

  state_e      state_q, state_d;
  logic [79:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [79:0] word_q, word_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  // One advance is 80 Fibonacci bit-steps, fully unrolled.
  function automatic logic [79:0] advance(input logic [79:0] s);
    logic [79:0] t;
    t = s;
    for (int i = 0; i < 80; i++) begin
      t = {t[78:0], t[79] ^ t[78] ^ t[42] ^ t[41]};
    end
    return t;
  endfunction

  assign lfsr_adv = advance(lfsr_q);

`ifdef DOM_RAND_HEALTH_EN
  logic [79:0] prev_q, prev_d;
  logic        alarm_q, alarm_d;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
`ifdef DOM_RAND_HEALTH_EN
    prev_d  = prev_q;
    alarm_d = alarm_q;
`endif
    // A seed strobe overrides any concurrent handshake; that handshake consumes nothing.
    if (seed_valid) begin
      lfsr_d  = (seed == '0) ? ZERO_SEED_SUB : seed;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = StWarmup;
`ifdef DOM_RAND_HEALTH_EN
      prev_d  = '0;
      alarm_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StWarmup: begin
          lfsr_d = lfsr_adv;
          if (cnt_q == WARMUP_CYCLES[7:0]) begin
            word_d  = lfsr_adv;
            valid_d = 1'b1;
            state_d = StRun;
`ifdef DOM_RAND_HEALTH_EN
            prev_d  = lfsr_adv;  // first word is stored but not compared
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StRun: begin
          if (valid_q && rnd_ready) begin
            lfsr_d = lfsr_adv;
            word_d = lfsr_adv;
`ifdef DOM_RAND_HEALTH_EN
            prev_d = lfsr_adv;
            if (lfsr_adv == prev_q) begin
              alarm_d = 1'b1;
              valid_d = 1'b0;
            end
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

`ifdef DOM_RAND_HEALTH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      alarm_q <= alarm_d;
    end
  end
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign rnd_valid = valid_q;
  assign r01 = word_q[7:0];
  assign r02 = word_q[15:8];
  assign r03 = word_q[23:16];
  assign r04 = word_q[31:24];
  assign r12 = word_q[39:32];
  assign r13 = word_q[47:40];
  assign r14 = word_q[55:48];
  assign r23 = word_q[63:56];
  assign r24 = word_q[71:64];
  assign r34 = word_q[79:72];

endmodule
